wb_mem_sequencer: RTL and testbench



---
 rtl/wb_mem_sequencer_pkg.sv | 31 +++
 rtl/wb_mem_sequencer_split_calc.sv | 35 +++
 rtl/wb_mem_sequencer.sv | 117 +++++++++++
 tb/tb_wb_mem_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_mem_sequencer_pkg : shared constants for the writeback store sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package wb_mem_sequencer_pkg;

  localparam int c_PAGE_BITS = 12;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_WR1    = 2'd1;
  localparam logic [1:0] c_ST_WR2    = 2'd2;
  localparam logic [1:0] c_ST_RETIRE = 2'd3;

  localparam logic [2:0] c_OPSZ_1 = 3'd1;
  localparam logic [2:0] c_OPSZ_2 = 3'd2;
  localparam logic [2:0] c_OPSZ_4 = 3'd4;

  // Encoding 3 is an alias for a 4-byte store.
  function automatic logic [2:0] sz_decode(input logic [1:0] op_size);
    logic [2:0] sz;
    case (op_size)
      2'd0:    sz = c_OPSZ_1;
      2'd1:    sz = c_OPSZ_2;
      default: sz = c_OPSZ_4;
    endcase
    return sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mem_sequencer_split_calc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_split_calc : decides whether a store spills into the next page and
// sizes the two pieces. Lengths are byte count minus one. Rev 1.0
// ---------------------------------------------------------------------------
module wb_split_calc
  import wb_mem_sequencer_pkg::*;
#(
  parameter int PAGE_BITS = c_PAGE_BITS
) (
  input  logic [PAGE_BITS-1:0] i_offset,
  input  logic [2:0]           i_sz,
  input  logic [1:0]           i_spill,
  output logic                 o_split,
  output logic [1:0]           o_len1,
  output logic [1:0]           o_len2,
  output logic [4:0]           o_shift
);

  localparam logic [PAGE_BITS:0] c_PAGE_SIZE = {1'b1, {PAGE_BITS{1'b0}}};

  logic [PAGE_BITS:0] w_n1;

  always_comb begin
    w_n1    = c_PAGE_SIZE - {1'b0, i_offset};
    o_split = (i_spill != 2'b00) && (w_n1 < (PAGE_BITS + 1)'(i_sz));
    // A split implies n1 <= 3, so two bits of n1 suffice; modulo-4 wrap
    // turns a 4-byte size into length code 3.
    o_len1  = (o_split ? w_n1[1:0] : i_sz[1:0]) - 2'd1;
    o_len2  = o_split ? (i_sz[1:0] - w_n1[1:0] - 2'd1) : 2'd0;
    o_shift = o_split ? {w_n1[1:0], 3'b000} : 5'd0;
  end

endmodule
`default_nettype wire

// File: rtl/wb_mem_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_mem_sequencer : drives one or two data-memory writes for a store held
// in the WB latch, stalls the latch until done, then pulses retire. Rev 1.0
// ---------------------------------------------------------------------------
module wb_mem_sequencer
  import wb_mem_sequencer_pkg::*;
#(
  parameter int PA_W      = 15,
  parameter int PAGE_BITS = c_PAGE_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_v,
  input  logic            i_memwr,
  input  logic [31:0]     i_data,
  input  logic [1:0]      i_opSize,
  input  logic [1:0]      i_spill,
  input  logic [PA_W-1:0] i_PA1,
  input  logic [PA_W-1:0] i_PA2,
  input  logic            i_mem_ack,
  output logic            o_mem_req,
  output logic [PA_W-1:0] o_mem_addr,
  output logic [1:0]      o_mem_len,
  output logic [31:0]     o_mem_data,
  output logic            o_stall,
  output logic            o_retire,
  output logic            o_busy
);

  logic [1:0]      r_state;
  logic [PA_W-1:0] r_pa2;
  logic [31:0]     r_data_hi;
  logic [1:0]      r_len2;
  logic            r_split;

  logic [2:0] w_sz;
  logic       w_split;
  logic [1:0] w_len1;
  logic [1:0] w_len2;
  logic [4:0] w_shift;
  logic       w_idle;

  assign w_sz   = sz_decode(i_opSize);
  assign w_idle = (r_state == c_ST_IDLE);

  wb_split_calc #(
    .PAGE_BITS (PAGE_BITS)
  ) u_split_calc (
    .i_offset (i_PA1[PAGE_BITS-1:0]),
    .i_sz     (w_sz),
    .i_spill  (i_spill),
    .o_split  (w_split),
    .o_len1   (w_len1),
    .o_len2   (w_len2),
    .o_shift  (w_shift)
  );

  // Gated by rst so nothing reaches the latch or register file during reset.
  assign o_stall  = rst & ((w_idle & i_v & i_memwr) |
                           (r_state == c_ST_WR1) | (r_state == c_ST_WR2));
  assign o_retire = rst & ((r_state == c_ST_RETIRE) | (w_idle & i_v & ~i_memwr));
  assign o_busy   = ~w_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_ST_IDLE;
      r_pa2      <= '0;
      r_data_hi  <= '0;
      r_len2     <= '0;
      r_split    <= 1'b0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_len  <= '0;
      o_mem_data <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (i_v && i_memwr) begin
            // The second piece is prepared now so WR2 only swaps registers.
            r_pa2      <= i_PA2;
            r_data_hi  <= i_data >> w_shift;
            r_len2     <= w_len2;
            r_split    <= w_split;
            o_mem_req  <= 1'b1;
            o_mem_addr <= i_PA1;
            o_mem_len  <= w_len1;
            o_mem_data <= i_data;
            r_state    <= c_ST_WR1;
          end
        end
        c_ST_WR1: begin
          if (i_mem_ack) begin
            if (r_split) begin
              o_mem_addr <= r_pa2;
              o_mem_len  <= r_len2;
              o_mem_data <= r_data_hi;
              r_state    <= c_ST_WR2;
            end else begin
              o_mem_req <= 1'b0;
              r_state   <= c_ST_RETIRE;
            end
          end
        end
        c_ST_WR2: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            r_state   <= c_ST_RETIRE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_mem_sequencer : directed self-checking bench for wb_mem_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_v = 1'b0;
  logic        i_memwr = 1'b0;
  logic [31:0] i_data = '0;
  logic [1:0]  i_opSize = '0;
  logic [1:0]  i_spill = '0;
  logic [14:0] i_PA1 = '0;
  logic [14:0] i_PA2 = '0;
  logic        i_mem_ack = 1'b0;
  logic        o_mem_req;
  logic [14:0] o_mem_addr;
  logic [1:0]  o_mem_len;
  logic [31:0] o_mem_data;
  logic        o_stall;
  logic        o_retire;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {req, stall, retire, busy} and {addr, len, data}
  wire [3:0]  obs_ctl = {o_mem_req, o_stall, o_retire, o_busy};
  wire [48:0] obs_bus = {o_mem_addr, o_mem_len, o_mem_data};

  always #5 clk = ~clk;

  wb_mem_sequencer #(
    .PA_W      (15),
    .PAGE_BITS (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_v        (i_v),
    .i_memwr    (i_memwr),
    .i_data     (i_data),
    .i_opSize   (i_opSize),
    .i_spill    (i_spill),
    .i_PA1      (i_PA1),
    .i_PA2      (i_PA2),
    .i_mem_ack  (i_mem_ack),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .o_mem_len  (o_mem_len),
    .o_mem_data (o_mem_data),
    .o_stall    (o_stall),
    .o_retire   (o_retire),
    .o_busy     (o_busy)
  );

  task automatic load_store(input logic [14:0] pa1, input logic [14:0] pa2,
                            input logic [1:0] op, input logic [1:0] spill,
                            input logic [31:0] data, input logic ack);
    i_v = 1'b1; i_memwr = 1'b1; i_PA1 = pa1; i_PA2 = pa2;
    i_opSize = op; i_spill = spill; i_data = data; i_mem_ack = ack;
  endtask

  task automatic test_reset();
    load_store(15'h0123, 15'h0, 2'd2, 2'd0, 32'h12345678, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", obs_ctl, 4'b0000); end
    n_checks++;
    if (obs_bus !== 49'd0) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", obs_bus, 49'd0); end
    @(posedge clk); #1;
    i_v = 1'b0; i_memwr = 1'b0; i_mem_ack = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_nonmem();
    @(posedge clk); #1;
    i_v = 1'b1; i_memwr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0010) begin n_fail++; $display("FAIL nonmem_retire: got %b expected %b", obs_ctl, 4'b0010); end
    @(posedge clk); #1;
    i_v = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0000) begin n_fail++; $display("FAIL nonmem_after: got %b expected %b", obs_ctl, 4'b0000); end
  endtask

  task automatic test_aligned();
    @(posedge clk); #1;
    load_store(15'h0100, 15'h0000, 2'd2, 2'd0, 32'hDDCCBBAA, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0100) begin n_fail++; $display("FAIL aligned_accept: got %b expected %b", obs_ctl, 4'b0100); end
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b1101) begin n_fail++; $display("FAIL aligned_wr1_ctl: got %b expected %b", obs_ctl, 4'b1101); end
    n_checks++;
    if (obs_bus !== {15'h0100, 2'd3, 32'hDDCCBBAA}) begin
      n_fail++; $display("FAIL aligned_wr1_bus: got %h expected %h", obs_bus, {15'h0100, 2'd3, 32'hDDCCBBAA});
    end
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0011) begin n_fail++; $display("FAIL aligned_retire: got %b expected %b", obs_ctl, 4'b0011); end
    @(posedge clk); #1;
    i_v = 1'b0; i_mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0000) begin n_fail++; $display("FAIL aligned_idle: got %b expected %b", obs_ctl, 4'b0000); end
  endtask

  task automatic test_split();
    @(posedge clk); #1;
    load_store(15'h0FFE, 15'h1000, 2'd2, 2'd1, 32'h44332211, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0100) begin n_fail++; $display("FAIL split_accept: got %b expected %b", obs_ctl, 4'b0100); end
    @(negedge clk);
    n_checks++;
    if (obs_bus !== {15'h0FFE, 2'd1, 32'h44332211}) begin
      n_fail++; $display("FAIL split_wr1_bus: got %h expected %h", obs_bus, {15'h0FFE, 2'd1, 32'h44332211});
    end
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b1101) begin n_fail++; $display("FAIL split_wr2_ctl: got %b expected %b", obs_ctl, 4'b1101); end
    n_checks++;
    if (obs_bus !== {15'h1000, 2'd1, 32'h00004433}) begin
      n_fail++; $display("FAIL split_wr2_bus: got %h expected %h", obs_bus, {15'h1000, 2'd1, 32'h00004433});
    end
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0011) begin n_fail++; $display("FAIL split_retire: got %b expected %b", obs_ctl, 4'b0011); end
    @(posedge clk); #1;
    i_v = 1'b0; i_mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0000) begin n_fail++; $display("FAIL split_single_retire: got %b expected %b", obs_ctl, 4'b0000); end
  endtask

  task automatic test_op3_split();
    @(posedge clk); #1;
    load_store(15'h0FFF, 15'h1000, 2'd3, 2'd2, 32'h89ABCDEF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (obs_bus !== {15'h0FFF, 2'd0, 32'h89ABCDEF}) begin
      n_fail++; $display("FAIL op3_wr1_bus: got %h expected %h", obs_bus, {15'h0FFF, 2'd0, 32'h89ABCDEF});
    end
    @(negedge clk);
    n_checks++;
    if (obs_bus !== {15'h1000, 2'd2, 32'h0089ABCD}) begin
      n_fail++; $display("FAIL op3_wr2_bus: got %h expected %h", obs_bus, {15'h1000, 2'd2, 32'h0089ABCD});
    end
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0011) begin n_fail++; $display("FAIL op3_retire: got %b expected %b", obs_ctl, 4'b0011); end
    @(posedge clk); #1;
    i_v = 1'b0; i_mem_ack = 1'b0;
  endtask

  task automatic test_delayed_ack();
    @(posedge clk); #1;
    load_store(15'h0234, 15'h0000, 2'd1, 2'd0, 32'hCAFEBEEF, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      i_mem_ack = (k == 5);
      @(negedge clk);
      n_checks++;
      if (obs_ctl !== 4'b1101) begin n_fail++; $display("FAIL delay_ctl[%0d]: got %b expected %b", k, obs_ctl, 4'b1101); end
      n_checks++;
      if (obs_bus !== {15'h0234, 2'd1, 32'hCAFEBEEF}) begin
        n_fail++; $display("FAIL delay_bus[%0d]: got %h expected %h", k, obs_bus, {15'h0234, 2'd1, 32'hCAFEBEEF});
      end
    end
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0011) begin n_fail++; $display("FAIL delay_retire: got %b expected %b", obs_ctl, 4'b0011); end
    @(posedge clk); #1;
    i_v = 1'b0; i_mem_ack = 1'b0;
  endtask

  task automatic test_spill_no_cross();
    @(posedge clk); #1;
    load_store(15'h0FFC, 15'h1000, 2'd2, 2'd1, 32'h0BADF00D, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (obs_bus !== {15'h0FFC, 2'd3, 32'h0BADF00D}) begin
      n_fail++; $display("FAIL nocross_bus: got %h expected %h", obs_bus, {15'h0FFC, 2'd3, 32'h0BADF00D});
    end
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0011) begin n_fail++; $display("FAIL nocross_retire: got %b expected %b", obs_ctl, 4'b0011); end
    @(posedge clk); #1;
    i_v = 1'b0; i_mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    load_store(15'h0FFE, 15'h1000, 2'd2, 2'd1, 32'h44332211, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b1101) begin n_fail++; $display("FAIL rstmid_wr2_ctl: got %b expected %b", obs_ctl, 4'b1101); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs_ctl !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async_drop: got %b expected %b", obs_ctl, 4'b0000); end
    @(posedge clk); #1;
    load_store(15'h0010, 15'h0000, 2'd0, 2'd0, 32'h0000005A, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0100) begin n_fail++; $display("FAIL rstmid_fresh_accept: got %b expected %b", obs_ctl, 4'b0100); end
    @(negedge clk);
    n_checks++;
    if (obs_bus !== {15'h0010, 2'd0, 32'h0000005A}) begin
      n_fail++; $display("FAIL rstmid_fresh_bus: got %h expected %h", obs_bus, {15'h0010, 2'd0, 32'h0000005A});
    end
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0011) begin n_fail++; $display("FAIL rstmid_fresh_retire: got %b expected %b", obs_ctl, 4'b0011); end
    @(posedge clk); #1;
    i_v = 1'b0; i_mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_ctl !== 4'b0000) begin n_fail++; $display("FAIL rstmid_idle: got %b expected %b", obs_ctl, 4'b0000); end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_aligned();
    test_split();
    test_op3_split();
    test_delayed_ack();
    test_spill_no_cross();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
